// File: rtl/huffman_pkg.sv
// Shared constants and FSM state type for the Huffman decoder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package huffman_pkg;

    localparam int SYMBOLS_MAX  = 32;
    localparam int MAX_CODE_LEN = 16;
    localparam int HEADER_BITS  = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_TABLE,
        WAIT_WORD,
        DECODE,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/huffman_decoder_if.sv
// Control, table-load, stream and result signals of the Huffman decoder.
// Latency: n/a (wiring only).
// Backpressure: wordReady tells the source when a step will latch wordIn.
interface huffman_decoder_if;

    logic        clockEnable;
    logic        manualReset;
    logic        tableLoaded;
    logic [31:0] symbol;
    logic [7:0]  symbolLength;
    logic [7:0]  character;
    logic [31:0] wordIn;
    logic        wordReady;
    logic [7:0]  charOut;
    logic        charValid;
    logic        done;
    logic        error;
    logic [15:0] log;

    // Stimulus side: drives steps, table entries and stream words.
    modport master (
        output clockEnable, manualReset, tableLoaded,
        output symbol, symbolLength, character, wordIn,
        input  wordReady, charOut, charValid, done, error, log
    );

    // Decoder side.
    modport slave (
        input  clockEnable, manualReset, tableLoaded,
        input  symbol, symbolLength, character, wordIn,
        output wordReady, charOut, charValid, done, error, log
    );

endinterface

// File: rtl/huffman_code_table.sv
// Code table storage with a fully parallel lookup of (code, length) -> character.
// Latency: writes land on the next clock; lookup is combinational.
// Backpressure: none; writes while full are dropped and reported through full.
module huffman_code_table #(
    parameter  int SYMBOLS_MAX  = 32,
    parameter  int MAX_CODE_LEN = 16,
    localparam int IDX_W        = $clog2(SYMBOLS_MAX + 1),
    localparam int LEN_W        = $clog2(MAX_CODE_LEN + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    wrEn,
    input  logic [MAX_CODE_LEN-1:0] wrCode,
    input  logic [7:0]              wrLen,
    input  logic [7:0]              wrChar,
    output logic                    full,
    input  logic [MAX_CODE_LEN-1:0] lookupCode,
    input  logic [LEN_W-1:0]        lookupLen,
    output logic                    hit,
    output logic [7:0]              hitChar
);

    localparam int ADDR_W = (SYMBOLS_MAX > 1) ? $clog2(SYMBOLS_MAX) : 1;

    logic [MAX_CODE_LEN-1:0] codeMem [SYMBOLS_MAX];
    logic [7:0]              lenMem  [SYMBOLS_MAX];
    logic [7:0]              charMem [SYMBOLS_MAX];
    logic [SYMBOLS_MAX-1:0]  valid;
    logic [IDX_W-1:0]        count;
    logic [ADDR_W-1:0]       wrAddr;
    logic                    doWrite;

    assign full    = (count == IDX_W'(SYMBOLS_MAX));
    assign wrAddr  = count[ADDR_W-1:0];
    assign doWrite = wrEn && !full;

    // Fill pointer and per-entry valid bits; clearing empties the table.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            valid <= '0;
        end else if (clear) begin
            count <= '0;
            valid <= '0;
        end else if (doWrite) begin
            valid[wrAddr] <= 1'b1;
            count         <= count + IDX_W'(1);
        end
    end

    // Entry payload; meaningless until the matching valid bit is set.
    always_ff @(posedge clock) begin
        if (doWrite) begin
            codeMem[wrAddr] <= wrCode;
            lenMem[wrAddr]  <= wrLen;
            charMem[wrAddr] <= wrChar;
        end
    end

    // Parallel compare against every valid entry; lowest index wins on duplicates.
    always_comb begin
        hit     = 1'b0;
        hitChar = '0;
        for (int i = 0; i < SYMBOLS_MAX; i++) begin
            if (!hit && valid[i] && lenMem[i] == 8'(lookupLen) && codeMem[i] == lookupCode) begin
                hit     = 1'b1;
                hitChar = charMem[i];
            end
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// Table-driven Huffman decoder: load code table, then decode a length-prefixed bit stream.
// Latency: one bit per clock in DECODE; charValid the cycle after a code's last bit.
// Backpressure: wordReady high only in WAIT_WORD; option HUFFMAN_DECODER_LOG_EN enables log.
module huffman_decoder #(
    parameter int SYMBOLS_MAX  = huffman_pkg::SYMBOLS_MAX,
    parameter int MAX_CODE_LEN = huffman_pkg::MAX_CODE_LEN
) (
    input logic              clock,
    input logic              reset,
    huffman_decoder_if.slave bus
);

    import huffman_pkg::*;

    localparam int LEN_W = $clog2(MAX_CODE_LEN + 1);

    state_t                  state;
    state_t                  nextState;
    logic                    cePrev;
    logic                    step;
    logic                    headerSeen;
    logic [15:0]             bitTotal;
    logic [15:0]             bitCount;
    logic [31:0]             shiftReg;
    logic [5:0]              bitsLeft;
    logic [MAX_CODE_LEN-1:0] acc;
    logic [LEN_W-1:0]        accLen;
    logic [MAX_CODE_LEN-1:0] candCode;
    logic [LEN_W-1:0]        candLen;
    logic                    matchHit;
    logic [7:0]              matchChar;
    logic                    tableFull;
    logic                    tableWrite;
    logic                    overflow;
    logic                    loadWord;
    logic                    shiftEn;
    logic                    emit;
    logic                    codeFault;
    logic                    errorFlag;
    logic                    unusedSymbolBits;

    // A step is a rising transition of clockEnable as sampled on clock.
    assign step = bus.clockEnable && !cePrev;

    // The accumulator as it will look once the current stream bit is shifted in.
    assign candCode = {acc[MAX_CODE_LEN-2:0], shiftReg[31]};
    assign candLen  = accLen + LEN_W'(1);

    assign unusedSymbolBits = ^bus.symbol[31:MAX_CODE_LEN];

    huffman_code_table #(
        .SYMBOLS_MAX (SYMBOLS_MAX),
        .MAX_CODE_LEN(MAX_CODE_LEN)
    ) codeTable (
        .clock     (clock),
        .reset     (reset),
        .clear     (bus.manualReset),
        .wrEn      (tableWrite),
        .wrCode    (bus.symbol[MAX_CODE_LEN-1:0]),
        .wrLen     (bus.symbolLength),
        .wrChar    (bus.character),
        .full      (tableFull),
        .lookupCode(candCode),
        .lookupLen (candLen),
        .hit       (matchHit),
        .hitChar   (matchChar)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (bus.manualReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        nextState  = state;
        tableWrite = 1'b0;
        overflow   = 1'b0;
        loadWord   = 1'b0;
        shiftEn    = 1'b0;
        emit       = 1'b0;
        codeFault  = 1'b0;
        case (state)
            IDLE: begin
                if (step) nextState = LOAD_TABLE;
            end
            LOAD_TABLE: begin
                if (step) begin
                    if (bus.tableLoaded) begin
                        nextState = WAIT_WORD;
                    end else if (bus.symbolLength != 8'd0) begin
                        if (tableFull) overflow = 1'b1;
                        else           tableWrite = 1'b1;
                    end
                end
            end
            WAIT_WORD: begin
                if (step) begin
                    loadWord = 1'b1;
                    // An empty stream finishes straight from the header word.
                    if (!headerSeen && bus.wordIn[31:16] == 16'd0) nextState = DONE;
                    else                                            nextState = DECODE;
                end
            end
            DECODE: begin
                shiftEn   = 1'b1;
                emit      = matchHit;
                codeFault = !matchHit && (candLen == LEN_W'(MAX_CODE_LEN));
                if (codeFault)                           nextState = ERROR;
                else if (bitCount + 16'd1 == bitTotal)   nextState = DONE;
                else if (bitsLeft == 6'd1)               nextState = WAIT_WORD;
            end
            default: ;
        endcase
    end

    // Stream datapath: word latch, bit shifter, code accumulator and output strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cePrev     <= 1'b0;
            headerSeen <= 1'b0;
            bitTotal   <= '0;
            bitCount   <= '0;
            shiftReg   <= '0;
            bitsLeft   <= '0;
            acc        <= '0;
            accLen     <= '0;
            bus.charOut   <= '0;
            bus.charValid <= 1'b0;
            errorFlag  <= 1'b0;
        end else if (bus.manualReset) begin
            cePrev     <= 1'b0;
            headerSeen <= 1'b0;
            bitTotal   <= '0;
            bitCount   <= '0;
            shiftReg   <= '0;
            bitsLeft   <= '0;
            acc        <= '0;
            accLen     <= '0;
            bus.charOut   <= '0;
            bus.charValid <= 1'b0;
            errorFlag  <= 1'b0;
        end else begin
            cePrev        <= bus.clockEnable;
            bus.charValid <= emit;
            if (emit) bus.charOut <= matchChar;
            if (overflow || codeFault) errorFlag <= 1'b1;
            if (loadWord) begin
                if (!headerSeen) begin
                    headerSeen <= 1'b1;
                    bitTotal   <= bus.wordIn[31:16];
                    shiftReg   <= {bus.wordIn[15:0], 16'h0000};
                    bitsLeft   <= 6'd16;
                end else begin
                    shiftReg   <= bus.wordIn;
                    bitsLeft   <= 6'd32;
                end
            end
            if (shiftEn) begin
                shiftReg <= {shiftReg[30:0], 1'b0};
                bitsLeft <= bitsLeft - 6'd1;
                bitCount <= bitCount + 16'd1;
                // Codes may straddle word boundaries, so the accumulator survives WAIT_WORD.
                if (emit) begin
                    acc    <= '0;
                    accLen <= '0;
                end else begin
                    acc    <= candCode;
                    accLen <= candLen;
                end
            end
        end
    end

    assign bus.wordReady = (state == WAIT_WORD);
    assign bus.done      = (state == DONE);
    assign bus.error     = errorFlag;

`ifdef HUFFMAN_DECODER_LOG_EN
    logic [15:0] logCount;

    // Saturating count of emitted characters, aligned with charValid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            logCount <= '0;
        end else if (bus.manualReset) begin
            logCount <= '0;
        end else if (emit && logCount != 16'hFFFF) begin
            logCount <= logCount + 16'd1;
        end
    end

    assign bus.log = logCount;
`else
    assign bus.log = '0;
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed self-checking bench for huffman_decoder.
// Latency: n/a.
// Backpressure: stream words are offered only while wordReady is high.
module tb_huffman_decoder;

    import huffman_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    huffman_decoder_if bus();

    huffman_decoder #(
        .SYMBOLS_MAX (32),
        .MAX_CODE_LEN(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    logic [7:0] gotChars [$];
    int         readyRises = 0;
    logic       readyPrev  = 1'b0;

    // Capture strobed characters and wordReady rising edges away from the clock edge.
    always @(negedge clock) begin
        if (bus.charValid === 1'b1) gotChars.push_back(bus.charOut);
        if (bus.wordReady === 1'b1 && readyPrev !== 1'b1) readyRises++;
        readyPrev = bus.wordReady;
    end

    function automatic int expLog(input int n);
`ifdef HUFFMAN_DECODER_LOG_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic pulseStep();
        @(negedge clock);
        bus.clockEnable = 1'b1;
        @(negedge clock);
        bus.clockEnable = 1'b0;
    endtask

    task automatic doReset();
        bus.clockEnable  = 1'b0;
        bus.manualReset  = 1'b0;
        bus.tableLoaded  = 1'b0;
        bus.symbol       = '0;
        bus.symbolLength = '0;
        bus.character    = '0;
        bus.wordIn       = '0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic writeEntry(input logic [31:0] code, input logic [7:0] len, input logic [7:0] ch);
        bus.tableLoaded  = 1'b0;
        bus.symbol       = code;
        bus.symbolLength = len;
        bus.character    = ch;
        pulseStep();
    endtask

    task automatic closeTable();
        bus.tableLoaded = 1'b1;
        pulseStep();
        bus.tableLoaded = 1'b0;
    endtask

    task automatic loadAbc();
        pulseStep();
        writeEntry(32'd0, 8'd1, 8'd65);
        writeEntry(32'd2, 8'd2, 8'd66);
        writeEntry(32'd3, 8'd2, 8'd67);
        closeTable();
    endtask

    task automatic sendWord(input logic [31:0] w);
        int n = 0;
        while (bus.wordReady !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (bus.wordReady !== 1'b1) begin
            errors++;
            $display("FAIL wordReady_wait got %b want 1 within 200 cycles", bus.wordReady);
        end
        bus.wordIn = w;
        pulseStep();
    endtask

    task automatic waitEnd();
        int n = 0;
        while (bus.done !== 1'b1 && dut.state !== ERROR && n < 500) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (bus.done !== 1'b1 && dut.state !== ERROR) begin
            errors++;
            $display("FAIL end_wait got state %0d want DONE or ERROR within 500 cycles", dut.state);
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if ({bus.wordReady, bus.charValid, bus.done, bus.error} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {bus.wordReady, bus.charValid, bus.done, bus.error});
        end
        checks++;
        if (bus.charOut !== 8'd0 || bus.log !== 16'd0) begin
            errors++;
            $display("FAIL reset_data got charOut %0d log %0d want 0 0", bus.charOut, bus.log);
        end
        checks++;
        if (dut.state !== IDLE || dut.codeTable.count !== 6'd0) begin
            errors++;
            $display("FAIL reset_state got state %0d count %0d want IDLE 0", dut.state, dut.codeTable.count);
        end
        loadAbc();
        checks++;
        if (bus.wordReady !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_load got %b want 1", bus.wordReady);
        end
        @(negedge clock);
        bus.manualReset = 1'b1;
        @(negedge clock);
        bus.manualReset = 1'b0;
        checks++;
        if (bus.wordReady !== 1'b0 || dut.state !== IDLE || dut.codeTable.count !== 6'd0) begin
            errors++;
            $display("FAIL manual_reset got ready %b state %0d count %0d want 0 IDLE 0",
                     bus.wordReady, dut.state, dut.codeTable.count);
        end
    endtask

    task automatic test_basic();
        logic [7:0] want [3];
        want[0] = 8'd65; want[1] = 8'd66; want[2] = 8'd67;
        doReset();
        gotChars.delete();
        loadAbc();
        sendWord(32'h0005_5800);
        waitEnd();
        checks++;
        if (gotChars.size() != 3) begin
            errors++;
            $display("FAIL basic_count got %0d want 3", gotChars.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= gotChars.size() || gotChars[i] !== want[i]) begin
                errors++;
                $display("FAIL basic_char%0d got %0d want %0d", i,
                         (i < gotChars.size()) ? gotChars[i] : 8'hxx, want[i]);
            end
        end
        checks++;
        if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.log !== 16'(expLog(3))) begin
            errors++;
            $display("FAIL basic_flags got done %b error %b log %0d want 1 0 %0d",
                     bus.done, bus.error, bus.log, expLog(3));
        end
    endtask

    task automatic test_multi_word();
        int bad = 0;
        doReset();
        gotChars.delete();
        readyRises = 0;
        loadAbc();
        sendWord(32'h0014_0000);
        sendWord(32'h0000_0000);
        waitEnd();
        checks++;
        if (gotChars.size() != 20) begin
            errors++;
            $display("FAIL multi_count got %0d want 20", gotChars.size());
        end
        foreach (gotChars[i]) if (gotChars[i] !== 8'd65) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL multi_chars got %0d non-65 characters want 0", bad);
        end
        checks++;
        if (readyRises != 2) begin
            errors++;
            $display("FAIL multi_ready_rises got %0d want 2", readyRises);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.log !== 16'(expLog(20))) begin
            errors++;
            $display("FAIL multi_flags got done %b log %0d want 1 %0d", bus.done, bus.log, expLog(20));
        end
    endtask

    task automatic test_no_match();
        doReset();
        gotChars.delete();
        pulseStep();
        writeEntry(32'd0, 8'd1, 8'd65);
        closeTable();
        sendWord(32'h0010_FFFF);
        waitEnd();
        checks++;
        if (gotChars.size() != 0) begin
            errors++;
            $display("FAIL nomatch_count got %0d want 0", gotChars.size());
        end
        checks++;
        if (bus.error !== 1'b1 || bus.done !== 1'b0 || dut.bitCount !== 16'd16) begin
            errors++;
            $display("FAIL nomatch_flags got error %b done %b bits %0d want 1 0 16",
                     bus.error, bus.done, dut.bitCount);
        end
        bus.wordIn = 32'h0001_0000;
        pulseStep();
        repeat (3) @(negedge clock);
        checks++;
        if (dut.state !== ERROR || bus.error !== 1'b1 || gotChars.size() != 0) begin
            errors++;
            $display("FAIL nomatch_sticky got state %0d error %b strobes %0d want ERROR 1 0",
                     dut.state, bus.error, gotChars.size());
        end
    endtask

    task automatic test_empty_stream();
        doReset();
        gotChars.delete();
        loadAbc();
        sendWord(32'h0000_1234);
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL empty_done got %b want 1", bus.done);
        end
        repeat (5) @(negedge clock);
        checks++;
        if (gotChars.size() != 0 || bus.error !== 1'b0) begin
            errors++;
            $display("FAIL empty_quiet got strobes %0d error %b want 0 0", gotChars.size(), bus.error);
        end
    endtask

    task automatic test_reset_mid_decode();
        logic [7:0] want [3];
        want[0] = 8'd65; want[1] = 8'd66; want[2] = 8'd67;
        doReset();
        gotChars.delete();
        loadAbc();
        sendWord(32'h0005_5800);
        repeat (2) @(negedge clock);
        checks++;
        if (dut.state !== DECODE) begin
            errors++;
            $display("FAIL midreset_pre got state %0d want DECODE", dut.state);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.wordReady, bus.charValid, bus.done, bus.error} !== 4'b0000 ||
            bus.charOut !== 8'd0 || bus.log !== 16'd0) begin
            errors++;
            $display("FAIL midreset_outputs got %b charOut %0d log %0d want 0000 0 0",
                     {bus.wordReady, bus.charValid, bus.done, bus.error}, bus.charOut, bus.log);
        end
        checks++;
        if (dut.state !== IDLE || dut.codeTable.count !== 6'd0) begin
            errors++;
            $display("FAIL midreset_state got state %0d count %0d want IDLE 0", dut.state, dut.codeTable.count);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (gotChars.size() != 1) begin
            errors++;
            $display("FAIL midreset_partial got %0d strobes want 1", gotChars.size());
        end
        gotChars.delete();
        loadAbc();
        sendWord(32'h0005_5800);
        waitEnd();
        checks++;
        if (gotChars.size() != 3) begin
            errors++;
            $display("FAIL rerun_count got %0d want 3", gotChars.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= gotChars.size() || gotChars[i] !== want[i]) begin
                errors++;
                $display("FAIL rerun_char%0d got %0d want %0d", i,
                         (i < gotChars.size()) ? gotChars[i] : 8'hxx, want[i]);
            end
        end
    endtask

    task automatic test_table_overflow();
        doReset();
        gotChars.delete();
        pulseStep();
        for (int i = 0; i < 32; i++) writeEntry(32'(32 + i), 8'd6, 8'(8'h80 + i));
        checks++;
        if (bus.error !== 1'b0) begin
            errors++;
            $display("FAIL overflow_pre got error %b want 0", bus.error);
        end
        writeEntry(32'd0, 8'd1, 8'h5A);
        checks++;
        if (bus.error !== 1'b1 || dut.codeTable.count !== 6'd32) begin
            errors++;
            $display("FAIL overflow_flag got error %b count %0d want 1 32", bus.error, dut.codeTable.count);
        end
        closeTable();
        sendWord(32'h0007_8000);
        waitEnd();
        checks++;
        if (gotChars.size() != 1 || gotChars[0] !== 8'h80) begin
            errors++;
            $display("FAIL overflow_match got %0d strobes first %0h want 1 strobe of 80",
                     gotChars.size(), (gotChars.size() > 0) ? gotChars[0] : 8'hxx);
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL overflow_done got %b want 1", bus.done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_word();
        test_no_match();
        test_empty_stream();
        test_reset_mid_decode();
        test_table_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/huffman_decoder.md
HUFFMAN_DECODER -- requirements
Module: huffman_decoder

Interface
REQ-001 SHALL have parameter SYMBOLS_MAX, default 32, table capacity in entries.
REQ-002 SHALL have parameter MAX_CODE_LEN, default 16, longest legal code in bits.
REQ-003 SHALL have port clock  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port clockEnable  in  1  step strobe; one step per low-to-high transition seen on clock.
REQ-006 SHALL have port manualReset  in  1  synchronous clear, same effect as reset.
REQ-007 SHALL have port tableLoaded  in  1  0 = step writes a table entry, 1 = step closes the table.
REQ-008 SHALL have port symbol  in  32  code value, right-aligned.
REQ-009 SHALL have port symbolLength  in  8  code length 1..MAX_CODE_LEN; 0 = entry ignored.
REQ-010 SHALL have port character  in  8  byte emitted for this code.
REQ-011 SHALL have port wordIn  in  32  encoded stream word, MSB first.
REQ-012 SHALL have port wordReady  out  1  high while a step will latch wordIn.
REQ-013 SHALL have ports charOut/charValid  out  8/1  decoded byte and its one-cycle strobe.
REQ-014 SHALL have ports done/error  out  1/1  sticky completion and fault flags.
REQ-015 SHALL have port log  out  16  decoded-character count.

Function
REQ-016 SHALL use states IDLE, LOAD_TABLE, WAIT_WORD, DECODE, DONE, ERROR.
REQ-017 SHALL go IDLE->LOAD_TABLE on the first step; in LOAD_TABLE, a step with tableLoaded=0 writes {symbol,symbolLength,character} at the next index.
REQ-018 SHALL ignore writes when the table is full (SYMBOLS_MAX entries) and assert error.
REQ-019 SHALL go LOAD_TABLE->WAIT_WORD on a step with tableLoaded=1.
REQ-020 SHALL treat the first stream word as the header: bits[31:16] = payload bit count N, bits[15:0] = first 16 payload bits.
REQ-021 SHALL treat each following word as 32 payload bits.
REQ-022 SHALL assert wordReady only in WAIT_WORD; a step there latches wordIn and enters DECODE.
REQ-023 SHALL in DECODE shift one bit per clock into an accumulator (length L) and compare it in parallel against all valid entries with length L.
REQ-024 SHALL on a match drive charOut=character and charValid=1 for exactly one cycle, the cycle after the completing bit, then clear L.
REQ-025 SHALL enter DONE when the consumed-bit count equals N, else WAIT_WORD when the word is exhausted.
REQ-026 SHALL enter DONE directly from the header word when N=0, with no charValid.
REQ-027 SHALL enter ERROR, set error=1 and emit nothing further when L reaches MAX_CODE_LEN without a match.
REQ-028 SHALL ignore steps in DECODE, DONE and ERROR.
REQ-029 SHALL ignore pad bits past N in the final word.
REQ-030 SHALL let only reset or manualReset leave DONE and ERROR.
REQ-031 SHALL use widths: bit counter 16 b, accumulator MAX_CODE_LEN b, index clog2(SYMBOLS_MAX+1) b.

Reset
REQ-032 SHALL on reset low or manualReset high: state=IDLE, table invalidated, counters=0, wordReady=0, charOut=0, charValid=0, done=0, error=0, log=0.
REQ-033 SHALL abort mid-decode on reset without emitting a partial character.

Configuration
REQ-034 SHALL with HUFFMAN_DECODER_LOG_EN defined make log count charValid pulses, saturating at 0xFFFF.
REQ-035 SHALL without HUFFMAN_DECODER_LOG_EN keep the log port and drive it constant 0.

Structure
REQ-036 SHALL place SYMBOLS_MAX, MAX_CODE_LEN, HEADER_BITS=16 and the state enum typedef in package huffman_pkg.
REQ-037 SHALL hold the table storage and parallel match logic in sub-module huffman_code_table.

Verification
REQ-038 SHALL test this case: table {A=0/1, B=10/2, C=11/2}, word 0x0005_5800 -> charOut 65, 66, 67 on three strobes, then done=1, log=3.
REQ-039 SHALL test this case: same table, words 0x0014_0000 then 0x0000_0000 -> 20 strobes of 65, wordReady reasserted once, done=1, log=20.
REQ-040 SHALL test this case: table {A=0/1}, word 0x0010_FFFF -> no strobe, error=1 after 16 bits, done=0.
REQ-041 SHALL test this case: word 0x0000_1234 -> done=1 immediately, no charValid.
REQ-042 SHALL test this case: reset pulsed low during DECODE of case REQ-038 -> all outputs 0, state IDLE, table empty; reload and rerun gives 65, 66, 67.
REQ-043 SHALL test this case: 33 entry writes with SYMBOLS_MAX=32 -> error=1, entry 33 absent from matching.
